prxtx_bridge_param: RTL

Parametrised next-generation PCIe/SFP transfer bridge for the PCIe kernel. On the receive side it buffers SFP words for host reads. On the send side it unpacks wide host beats into words, drops filler, and serves them to the SFP side one word per `send_start`. Adds runtime-programmable interrupt thresholds, edge-triggered IRQs, overflow/underrun accounting and width/depth parameters.

---
 rtl/prxtx_bridge_param.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/prxtx_bridge_param.sv
// PCIe/SFP transfer bridge: buffers SFP words for host reads, and unpacks wide host
// beats (filler dropped) into a send FIFO drained one word per send_start.
module prxtx_bridge_param #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned HOST_RATIO  = 16,
  parameter int unsigned RX_AW       = 12,
  parameter int unsigned TX_AW       = 9,
  parameter int unsigned BURST_WORDS = 16,
  parameter int unsigned RX_AFULL    = 4000
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         sfp_wr_en,
  input  logic [2*DATA_W-1:0]          sfp_wr_data,
  input  logic                         send_start,
  output logic [2*DATA_W-1:0]          sfp_rd_data,
  output logic                         rece_qune,
  output logic                         send_statue,
  input  logic                         avm_rd_ready,
  output logic                         avm_rd_vaild,
  output logic [DATA_W-1:0]            avm_rd_data,
  input  logic                         avm_wr_vaild,
  output logic                         avm_wr_ready,
  input  logic [DATA_W*HOST_RATIO-1:0] avm_wr_data,
  input  logic [RX_AW:0]               rx_irq_thresh,
  input  logic [TX_AW:0]               tx_irq_thresh,
  output logic                         rece_irq,
  input  logic                         rece_ack,
  output logic                         send_irq,
  input  logic                         send_ack,
  output logic [31:0]                  rece_fifo_usedw,
  output logic [31:0]                  send_fifo_usedw,
  output logic [15:0]                  rx_drop_cnt,
  output logic [15:0]                  tx_underrun_cnt
);

  localparam int unsigned IdxW = (HOST_RATIO > 1) ? $clog2(HOST_RATIO) : 1;
  localparam logic [RX_AW:0] RxDepth = {1'b1, {RX_AW{1'b0}}};
  localparam logic [TX_AW:0] TxDepth = {1'b1, {TX_AW{1'b0}}};
  localparam logic [IdxW-1:0] IdxLast = IdxW'(HOST_RATIO - 1);

  // Receive FIFO state
  logic [DATA_W-1:0] rx_mem [2**RX_AW];
  logic [RX_AW-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RX_AW:0]    rx_cnt_q, rx_cnt_d;
  logic [15:0]       rx_drop_q, rx_drop_d;
  logic              rx_full, rx_empty, rx_push, rx_pop, rx_drop;

  // Send FIFO and unpacker state
  logic [DATA_W-1:0]                  tx_mem [2**TX_AW];
  logic [TX_AW-1:0]                   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TX_AW:0]                     tx_cnt_q, tx_cnt_d;
  logic [15:0]                        tx_unr_q, tx_unr_d;
  logic [2*DATA_W-1:0]                rd_data_q, rd_data_d;
  logic [HOST_RATIO-1:0][DATA_W-1:0]  beat_q, beat_d;
  logic [IdxW-1:0]                    idx_q, idx_d;
  logic                               busy_q, busy_d;
  logic [DATA_W-1:0]                  cur_word;
  logic                               tx_full, tx_empty, tx_pop, up_push, up_adv, beat_accept;

  // Interrupt state
  logic           rx_cond, rx_cond_q, rx_irq_set, rece_irq_q, rece_irq_d;
  logic           tx_cond, tx_cond_q, tx_irq_set, send_irq_q, send_irq_d;
  logic [RX_AW:0] rx_thr_q;
  logic [TX_AW:0] tx_thr_q;

  logic [31:0] rx_round;
  logic        unused_lo;

  assign unused_lo = ^sfp_wr_data[DATA_W-1:0];

  always_comb begin
    rx_full   = (rx_cnt_q == RxDepth);
    rx_empty  = (rx_cnt_q == '0);
    rx_pop    = avm_rd_ready && !rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    rx_push   = sfp_wr_en && (!rx_full || rx_pop);
    rx_drop   = sfp_wr_en && !rx_push;
    rx_wptr_d = rx_wptr_q + RX_AW'(rx_push);
    rx_rptr_d = rx_rptr_q + RX_AW'(rx_pop);
    rx_cnt_d  = rx_cnt_q + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
    rx_drop_d = (rx_drop && (rx_drop_q != 16'hFFFF)) ? rx_drop_q + 16'd1 : rx_drop_q;
  end

  always_comb begin
    tx_full     = (tx_cnt_q == TxDepth);
    tx_empty    = (tx_cnt_q == '0);
    cur_word    = beat_q[idx_q];
    up_push     = busy_q && (cur_word != '1) && !tx_full;
    up_adv      = busy_q && ((cur_word == '1) || !tx_full);
    beat_accept = avm_wr_vaild && !busy_q;
    tx_pop      = send_start && !tx_empty;

    beat_d = beat_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    if (beat_accept) begin
      beat_d = avm_wr_data;
      idx_d  = '0;
      busy_d = 1'b1;
    end else if (up_adv) begin
      idx_d = idx_q + IdxW'(1);
      if (idx_q == IdxLast) busy_d = 1'b0;
    end

    tx_wptr_d = tx_wptr_q + TX_AW'(up_push);
    tx_rptr_d = tx_rptr_q + TX_AW'(tx_pop);
    tx_cnt_d  = tx_cnt_q + (TX_AW+1)'(up_push) - (TX_AW+1)'(tx_pop);

    rd_data_d = rd_data_q;
    tx_unr_d  = tx_unr_q;
    if (send_start) begin
      if (tx_empty) begin
        rd_data_d = '1;
        if (tx_unr_q != 16'hFFFF) tx_unr_d = tx_unr_q + 16'd1;
      end else begin
        rd_data_d = {tx_mem[tx_rptr_q], {DATA_W{1'b0}}};
      end
    end
  end

  // IRQs fire on a rising threshold condition or on a threshold rewrite that lands below
  // the count; ack has priority.
  always_comb begin
    rx_cond    = (rx_irq_thresh != '0) && (rx_cnt_q >= rx_irq_thresh);
    rx_irq_set = rx_cond && (!rx_cond_q || (rx_irq_thresh != rx_thr_q));
    rece_irq_d = rece_ack ? 1'b0 : (rx_irq_set ? 1'b1 : rece_irq_q);
    tx_cond    = (tx_irq_thresh != '0) && (tx_cnt_q >= tx_irq_thresh);
    tx_irq_set = tx_cond && (!tx_cond_q || (tx_irq_thresh != tx_thr_q));
    send_irq_d = send_ack ? 1'b0 : (tx_irq_set ? 1'b1 : send_irq_q);
  end

  always_ff @(posedge ap_clk) begin
    if (rx_push) rx_mem[rx_wptr_q] <= sfp_wr_data[2*DATA_W-1:DATA_W];
    if (up_push) tx_mem[tx_wptr_q] <= cur_word;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      rx_drop_q  <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      tx_unr_q   <= '0;
      rd_data_q  <= '1;
      beat_q     <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      rx_cond_q  <= 1'b0;
      tx_cond_q  <= 1'b0;
      rx_thr_q   <= '0;
      tx_thr_q   <= '0;
      rece_irq_q <= 1'b0;
      send_irq_q <= 1'b0;
    end else begin
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_drop_q  <= rx_drop_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_unr_q   <= tx_unr_d;
      rd_data_q  <= rd_data_d;
      beat_q     <= beat_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      rx_cond_q  <= rx_cond;
      tx_cond_q  <= tx_cond;
      rx_thr_q   <= rx_irq_thresh;
      tx_thr_q   <= tx_irq_thresh;
      rece_irq_q <= rece_irq_d;
      send_irq_q <= send_irq_d;
    end
  end

  always_comb begin
    avm_rd_vaild    = avm_rd_ready;
    avm_rd_data     = rx_empty ? '1 : rx_mem[rx_rptr_q];
    send_statue     = (rx_cnt_q <= (RX_AW+1)'(RX_AFULL));
    rx_round        = (32'(rx_cnt_q) + 32'(BURST_WORDS - 1)) & ~32'(BURST_WORDS - 1);
    rece_fifo_usedw = rx_round * 32'(DATA_W / 8);
    send_fifo_usedw = 32'(tx_cnt_q);
    rece_qune       = !tx_empty;
    avm_wr_ready    = !busy_q;
    sfp_rd_data     = rd_data_q;
    rece_irq        = rece_irq_q;
    send_irq        = send_irq_q;
    rx_drop_cnt     = rx_drop_q;
    tx_underrun_cnt = tx_unr_q;
  end

endmodule
